fetch_stream: RTL and testbench
===============================

Name: fetch_stream

Overview:
Parametrised successor to the single-slot instruction fetch unit. Issues line-aligned, in-order requests to instruction memory and keeps up to MaxOutstanding requests in flight. Unpacks every instruction in a returned line from the fetch offset onward into a PC-tagged instruction queue. On a redirect it flushes in one cycle and discards stale responses with a drop counter. Sits between the instruction memory port and decode.

Parameters:
Xlen, 64, address/PC width
Ilen, 32, instruction width
MemWidth, 64, memory data width; multiple of Ilen; Slots = MemWidth/Ilen (power of 2, ≥1)
BootAddr, 'h0, first fetch PC after reset (Ilen/8-aligned)
QueueDepthLog2, 3, instruction queue depth = 2**QueueDepthLog2 entries (≥ Slots)
MaxOutstanding, 2, max requests accepted but not yet answered (1..7)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
redirect_i  in  1  control hazard; flush and refetch from redirect_pc_i
redirect_pc_i  in  Xlen  redirect target; low log2(Ilen/8) bits ignored
mem_ready_i  in  1  memory accepts request
mem_valid_o  out  1  request valid
mem_addr_o  out  Xlen  line-aligned request address (low log2(MemWidth/8) bits zero)
mem_rdata_i  in  MemWidth  response line
mem_rvalid_i  in  1  response valid; responses return in request order, any latency ≥1
inst_ready_i  in  1  consumer accepts head instruction
inst_valid_o  out  1  queue non-empty
inst_pc_o  out  Xlen  PC of head instruction
inst_data_o  out  Ilen  head instruction
outstanding_o  out  3  requests in flight (debug/perf)

Behaviour:
- One clock; synchronous active-high reset. Reset is legal mid-operation: it discards queue contents and in-flight bookkeeping. A response arriving in the cycle after reset is ignored only if drop_cnt covers it; memory must be quiesced with reset.
- Reset values: inst_valid_o=0, mem_valid_o=0 in the reset cycle, outstanding_o=0, drop_cnt=0, fetch_pc=BootAddr, queue empty; inst_pc_o/inst_data_o are don't-care while invalid.
- Fetch PC: fetch_pc_d = redirect_i ? redirect_pc_i : fetch_pc_q. mem_addr_o = fetch_pc_d with the line-offset bits cleared. Start slot s = fetch_pc_d[offset bits]/(Ilen/8).
- Request side: on a handshake (mem_valid_o && mem_ready_i), push {line_addr, s} into a MaxOutstanding-deep pending FIFO, then fetch_pc_q ← line_addr + MemWidth/8 (next line, s=0). Wraps modulo 2**Xlen.
- Credit rule: mem_valid_o = !rst_i && (outstanding < MaxOutstanding) && (queue_count + reserved + Slots ≤ QueueDepth). reserved = sum of (Slots − s) over in-flight non-dropped requests. The queue can therefore never overflow.
- mem_valid_o may assert in a redirect cycle and then carries the target line. Credits in that cycle are computed as if the queue were already empty and reserved=0.
- Response side: when mem_rvalid_i && drop_cnt==0, pop the pending FIFO. Write instructions from slot s through Slots−1 into the queue in ascending order in the same cycle. Each entry's PC = line_addr + slot·(Ilen/8). Entries are visible on inst_* the next cycle (1-cycle write-to-read latency).
- Dropped responses: when mem_rvalid_i && drop_cnt>0, decrement drop_cnt, pop pending, write nothing.
- Redirect cycle: the queue is emptied (a head pop in the same cycle is void). drop_cnt ← outstanding_q − (mem_rvalid_i && drop_cnt==0 ? 1 : 0) + (drop_cnt>0 && mem_rvalid_i ? −1 : 0), i.e. every request issued before the redirect is dropped. A response arriving in the redirect cycle is discarded. Back-to-back redirects accumulate correctly.
- Queue: power-of-two circular buffer, pointers QueueDepthLog2+1 bits with wrap bit. Full = same index, different wrap bit. Up to Slots writes and 1 read per cycle. Simultaneous pop and multi-push when full-minus-reserved is legal.
- outstanding_q: +1 on request handshake, −1 on any accepted response, both in the same cycle → unchanged.
- A response arriving with outstanding_q==0 is a protocol violation; assertion only.

Test Plan:
- Reset, BootAddr=0x1000, MemWidth=64, mem latency 1, inst_ready_i=1 → requests 0x1000, 0x1008, 0x1010…; inst_pc_o sequence 0x1000, 0x1004, 0x1008…, data matching the line halves; no gaps after warm-up.
- Redirect to 0x2004 while 2 requests are outstanding → both stale responses dropped (drop_cnt 2→0); first output PC 0x2004 (slot 1 only); next 0x2008.
- inst_ready_i=0 for 20 cycles, QueueDepthLog2=3 → queue fills to 8, mem_valid_o deasserts with no overflow and no lost PCs; releasing ready resumes in order.
- Redirect in the same cycle as mem_rvalid_i and a head pop → that response is discarded, queue is empty next cycle, and the request issued that cycle is to the target line.
- Two redirects 1 cycle apart (0x3000, then 0x4000) with latency 3 → only PCs from 0x4000 ever appear on inst_pc_o.
- Fetch across the top of the address space (fetch_pc 0xFFFF_FFFF_FFFF_FFF8) → next request 0x0; PCs wrap without stalling.

Source files
------------

// File: rtl/fetch_stream.sv
// Streaming instruction fetch: in-order line requests with a credit-limited
// in-flight window, unpacked into a PC-tagged instruction queue for decode.
module fetch_stream #(
  parameter int unsigned     Xlen           = 64,
  parameter int unsigned     Ilen           = 32,
  parameter int unsigned     MemWidth       = 64,
  parameter logic [Xlen-1:0] BootAddr       = '0,
  parameter int unsigned     QueueDepthLog2 = 3,
  parameter int unsigned     MaxOutstanding = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                redirect_i,
  input  logic [Xlen-1:0]     redirect_pc_i,
  input  logic                mem_ready_i,
  output logic                mem_valid_o,
  output logic [Xlen-1:0]     mem_addr_o,
  input  logic [MemWidth-1:0] mem_rdata_i,
  input  logic                mem_rvalid_i,
  input  logic                inst_ready_i,
  output logic                inst_valid_o,
  output logic [Xlen-1:0]     inst_pc_o,
  output logic [Ilen-1:0]     inst_data_o,
  output logic [2:0]          outstanding_o
);

  localparam int unsigned Slots     = MemWidth / Ilen;
  localparam int unsigned IBytes    = Ilen / 8;
  localparam int unsigned LineBytes = MemWidth / 8;
  localparam int unsigned OffW      = $clog2(LineBytes);
  localparam int unsigned IOffW     = $clog2(IBytes);
  localparam int unsigned SlotW     = (Slots > 1) ? $clog2(Slots) : 1;
  localparam int unsigned Depth     = 2 ** QueueDepthLog2;
  localparam int unsigned QIdxW     = QueueDepthLog2;
  localparam int unsigned PtrW      = QueueDepthLog2 + 1;
  localparam int unsigned SumW      = QueueDepthLog2 + 3;
  localparam int unsigned PendW     = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  logic [Xlen-1:0]  fetch_pc_q, fetch_pc_d, line_addr;
  logic [SlotW-1:0] req_slot;
  logic [2:0]       outstanding_q, drop_cnt_q;
  logic [PtrW-1:0]  reserved_q, reserved_d;
  logic [PtrW-1:0]  wr_ptr, rd_ptr, q_count;
  logic [PtrW-1:0]  req_left, rsp_left, push_n;
  logic [SumW-1:0]  credit_sum;
  logic             hs, rsp_take, pop;

  logic [Xlen-1:0]  pend_addr [MaxOutstanding];
  logic [SlotW-1:0] pend_slot [MaxOutstanding];
  logic [PendW-1:0] pend_wr, pend_rd;
  logic [Xlen-1:0]  rsp_addr;
  logic [SlotW-1:0] rsp_slot;

  logic [Xlen-1:0]  q_pc   [Depth];
  logic [Ilen-1:0]  q_data [Depth];

  function automatic logic [PendW-1:0] pend_inc(input logic [PendW-1:0] p);
    return (32'(p) == MaxOutstanding - 1) ? '0 : p + PendW'(1);
  endfunction

  // Request address and start slot follow the redirect target combinationally
  always_comb begin
    fetch_pc_d = redirect_i ? redirect_pc_i : fetch_pc_q;
    line_addr  = fetch_pc_d & ~Xlen'(LineBytes - 1);
    req_slot   = SlotW'(fetch_pc_d[OffW-1:0] >> IOffW);
    req_left   = PtrW'(Slots) - PtrW'(req_slot);
  end

  // A redirect frees the whole queue and all reservations in its own cycle
  always_comb begin
    q_count     = wr_ptr - rd_ptr;
    credit_sum  = SumW'(redirect_i ? '0 : q_count) + SumW'(redirect_i ? '0 : reserved_q)
                + SumW'(Slots);
    mem_valid_o = !rst_i && (32'(outstanding_q) < MaxOutstanding)
                  && (credit_sum <= SumW'(Depth));
    mem_addr_o  = line_addr;
    hs          = mem_valid_o && mem_ready_i;
  end

  always_comb begin
    rsp_addr = pend_addr[pend_rd];
    rsp_slot = pend_slot[pend_rd];
    rsp_left = PtrW'(Slots) - PtrW'(rsp_slot);
    rsp_take = mem_rvalid_i && (drop_cnt_q == 3'd0) && !redirect_i;
    push_n   = rsp_take ? rsp_left : '0;
    pop      = inst_valid_o && inst_ready_i && !redirect_i;
    reserved_d = (redirect_i ? '0 : reserved_q - (rsp_take ? rsp_left : '0))
               + (hs ? req_left : '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc_q    <= BootAddr;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      reserved_q    <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      pend_wr       <= '0;
      pend_rd       <= '0;
    end else begin
      fetch_pc_q    <= hs ? line_addr + Xlen'(LineBytes) : fetch_pc_d;
      outstanding_q <= outstanding_q + 3'(hs) - 3'(mem_rvalid_i);
      reserved_q    <= reserved_d;
      // Everything issued before the redirect is stale, minus the one answered now
      if (redirect_i)
        drop_cnt_q <= outstanding_q - 3'(mem_rvalid_i);
      else if (mem_rvalid_i && drop_cnt_q != 3'd0)
        drop_cnt_q <= drop_cnt_q - 3'd1;
      if (hs)           pend_wr <= pend_inc(pend_wr);
      if (mem_rvalid_i) pend_rd <= pend_inc(pend_rd);
      if (redirect_i) begin
        rd_ptr <= wr_ptr;
      end else begin
        wr_ptr <= wr_ptr + push_n;
        rd_ptr <= rd_ptr + PtrW'(pop);
      end
    end
  end

  // Payload storage; slots from the fetch offset onward land in ascending order
  always_ff @(posedge clk_i) begin
    if (hs) begin
      pend_addr[pend_wr] <= line_addr;
      pend_slot[pend_wr] <= req_slot;
    end
    for (int k = 0; k < Slots; k++) begin
      if (rsp_take && (SlotW'(k) >= rsp_slot)) begin
        q_pc[QIdxW'(wr_ptr + PtrW'(k) - PtrW'(rsp_slot))]   <= rsp_addr + Xlen'(k * IBytes);
        q_data[QIdxW'(wr_ptr + PtrW'(k) - PtrW'(rsp_slot))] <= mem_rdata_i[k*Ilen +: Ilen];
      end
    end
  end

  always_comb begin
    inst_valid_o  = (q_count != '0);
    inst_pc_o     = q_pc[rd_ptr[QIdxW-1:0]];
    inst_data_o   = q_data[rd_ptr[QIdxW-1:0]];
    outstanding_o = outstanding_q;
  end

  // A response with nothing in flight is a memory-side protocol violation
  always_ff @(posedge clk_i) begin
    if (!rst_i && mem_rvalid_i) assert (outstanding_q != 3'd0);
  end

endmodule

// File: tb/tb_fetch_stream.sv
// Bench for fetch_stream: in-order memory model with variable latency and an
// abstract program-order model of the expected request and instruction streams.
module tb_fetch_stream;

  localparam logic [63:0] Boot = 64'h1000;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        redirect_i = 1'b0;
  logic [63:0] redirect_pc_i = '0;
  logic        mem_ready_i = 1'b0;
  logic        mem_valid_o;
  logic [63:0] mem_addr_o;
  logic [63:0] mem_rdata_i = '0;
  logic        mem_rvalid_i = 1'b0;
  logic        inst_ready_i = 1'b0;
  logic        inst_valid_o;
  logic [63:0] inst_pc_o;
  logic [31:0] inst_data_o;
  logic [2:0]  outstanding_o;

  always #5 clk = ~clk;

  fetch_stream #(
    .Xlen(64), .Ilen(32), .MemWidth(64), .BootAddr(Boot),
    .QueueDepthLog2(3), .MaxOutstanding(2)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .mem_ready_i(mem_ready_i), .mem_valid_o(mem_valid_o), .mem_addr_o(mem_addr_o),
    .mem_rdata_i(mem_rdata_i), .mem_rvalid_i(mem_rvalid_i),
    .inst_ready_i(inst_ready_i), .inst_valid_o(inst_valid_o),
    .inst_pc_o(inst_pc_o), .inst_data_o(inst_data_o), .outstanding_o(outstanding_o)
  );

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_due = 0;
  int lat = 1;
  bit rand_lat = 0;
  logic [63:0] mq_addr[$];
  int          mq_due[$];
  logic [63:0] exp_pc = Boot;
  logic [63:0] exp_req = Boot;
  bit last_iv, last_rv, last_mv;

  function automatic logic [31:0] word_at(input logic [63:0] a);
    return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [63:0] line_data(input logic [63:0] a);
    return {word_at(a + 64'd4), word_at(a)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // One clock of stimulus; entered and left at posedge+1, samples at negedge
  task automatic step(input bit redir, input logic [63:0] tgt, input bit irdy, input bit mrdy);
    bit rv = 0;
    int exp_out = mq_addr.size();
    logic [63:0] cur_req;
    int due;
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      rv = 1;
      mem_rdata_i = line_data(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    mem_rvalid_i  = rv;
    redirect_i    = redir;
    redirect_pc_i = tgt;
    inst_ready_i  = irdy;
    mem_ready_i   = mrdy;
    @(negedge clk);
    chk("outstanding", 64'(outstanding_o), 64'(exp_out));
    cur_req = redir ? (tgt & ~64'd7) : exp_req;
    if (mem_valid_o) chk("mem_addr", mem_addr_o, cur_req);
    if (mem_valid_o && mrdy) begin
      due = cyc + (rand_lat ? int'($urandom_range(1, 4)) : lat);
      if (due < last_due) due = last_due;
      last_due = due;
      mq_addr.push_back(cur_req);
      mq_due.push_back(due);
      exp_req = cur_req + 64'd8;
    end else if (redir) begin
      exp_req = cur_req;
    end
    if (redir) begin
      exp_pc = tgt & ~64'd3;
    end else if (inst_valid_o && irdy) begin
      chk("inst_pc", inst_pc_o, exp_pc);
      chk("inst_data", 64'(inst_data_o), 64'(word_at(exp_pc)));
      exp_pc = exp_pc + 64'd4;
    end
    last_iv = inst_valid_o;
    last_rv = rv;
    last_mv = mem_valid_o;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    bit found;
    // Reset behaviour
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_valid", 64'(mem_valid_o), 64'd0);
    chk("rst_inst_valid", 64'(inst_valid_o), 64'd0);
    chk("rst_outstanding", 64'(outstanding_o), 64'd0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    mem_ready_i = 1'b1;
    #1;
    chk("boot_valid", 64'(mem_valid_o), 64'd1);
    chk("boot_addr", mem_addr_o, Boot);

    // Streaming at latency 1 with a continuously ready consumer
    for (int i = 0; i < 40; i++) begin
      step(0, '0, 1, 1);
      if (i >= 10) chk("no_gap", 64'(last_iv), 64'd1);
    end

    // Redirect with two requests in flight
    lat = 3;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (outstanding_o == 3'd2) found = 1;
      else step(0, '0, 1, 1);
    end
    chk("two_outstanding", 64'(found), 64'd1);
    step(1, 64'h2004, 1, 1);
    for (int i = 0; i < 25; i++) step(0, '0, 1, 1);

    // Consumer stall fills the queue and throttles requests
    lat = 1;
    for (int i = 0; i < 20; i++) step(0, '0, 0, 1);
    chk("stall_no_req", 64'(mem_valid_o), 64'd0);
    chk("stall_valid", 64'(inst_valid_o), 64'd1);
    for (int i = 0; i < 30; i++) step(0, '0, 1, 1);

    // Redirect coinciding with a response and a head pop
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mq_addr.size() > 0 && mq_due[0] <= cyc && inst_valid_o) found = 1;
      else step(0, '0, 1, 1);
    end
    chk("coincide_found", 64'(found), 64'd1);
    step(1, 64'h5008, 1, 1);
    chk("coincide_rvalid", 64'(last_rv), 64'd1);
    chk("coincide_req", 64'(last_mv), 64'd1);
    chk("coincide_empty", 64'(inst_valid_o), 64'd0);
    for (int i = 0; i < 15; i++) step(0, '0, 1, 1);

    // Back-to-back redirects at latency 3
    lat = 3;
    step(1, 64'h3000, 1, 1);
    step(1, 64'h4000, 1, 1);
    for (int i = 0; i < 30; i++) step(0, '0, 1, 1);

    // Fetch across the top of the address space
    lat = 1;
    step(1, 64'hFFFF_FFFF_FFFF_FFF8, 1, 1);
    for (int i = 0; i < 15; i++) step(0, '0, 1, 1);
    chk("wrap_pc_region", 64'(exp_pc < 64'h100), 64'd1);

    // Randomized traffic with occasional redirects
    rand_lat = 1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) < 3)
        step(1, {32'h0, $urandom}, ($urandom_range(0, 9) < 7), ($urandom_range(0, 3) != 0));
      else
        step(0, '0, ($urandom_range(0, 9) < 7), ($urandom_range(0, 3) != 0));
    end

    // Drain the memory pipe
    rand_lat = 0;
    for (int i = 0; i < 40 && mq_addr.size() > 0; i++) step(0, '0, 1, 0);
    chk("drain_empty", 64'(mq_addr.size()), 64'd0);
    step(0, '0, 1, 0);
    chk("drain_outstanding", 64'(outstanding_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
